// File: rtl/bf_addr_ctrl.sv
// bf_addr_ctrl
//   Address sequencer for an in-place, memory-based radix-2 DIF FFT of
//   N = 2**N_LOG2 points. Issues one butterfly per cycle (A/B read addresses
//   plus twiddle-ROM index), steps through all N_LOG2 stages with a LAT-cycle
//   drain between stages, and returns the write-back addresses LAT cycles
//   after issue.
//
//   Optional feature: define BF_ADDR_CTRL_HOLD_EN to add the 'hold' input,
//   which stalls issue in RUN (bubbles still flow down the write path).
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin an FFT (sampled only in IDLE)
//   hold       in   stall issue in RUN (only with BF_ADDR_CTRL_HOLD_EN)
//   busy       out  FFT in progress
//   done       out  one-cycle pulse after the last write-back
//   stage      out  current stage index
//   rd_en      out  read-issue strobe
//   rd_a_addr  out  A operand address
//   rd_b_addr  out  B operand address
//   tw_addr    out  twiddle ROM index
//   wr_en      out  rd_en delayed by LAT
//   wr_a_addr  out  rd_a_addr delayed by LAT
//   wr_b_addr  out  rd_b_addr delayed by LAT
module bf_addr_ctrl #(
    parameter int N_LOG2 = 4,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
`ifdef BF_ADDR_CTRL_HOLD_EN
    input  logic              hold,
`endif
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_a_addr,
    output logic [N_LOG2-1:0] rd_b_addr,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_a_addr,
    output logic [N_LOG2-1:0] wr_b_addr
);

    localparam int CW = $clog2(LAT + 1);
    localparam logic [N_LOG2-2:0] K_LAST   = '1;
    localparam logic [N_LOG2-1:0] S_LAST   = N_LOG2'(N_LOG2 - 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t              state;
    logic [N_LOG2-2:0]   k;      // index of the most recently issued butterfly
    logic [CW-1:0]       cnt;
    logic                stall;

`ifdef BF_ADDR_CTRL_HOLD_EN
    always_comb stall = hold;
`else
    always_comb stall = 1'b0;
`endif

    // Returns {a, b, tw} for butterfly k of stage s.
    // span = N>>(s+1); a = grp*2*span + j; b = a + span; tw = j<<s mod N/2
    function automatic logic [3*N_LOG2-2:0] bf_addr(input logic [N_LOG2-1:0] s,
                                                    input logic [N_LOG2-2:0] kin);
        logic [N_LOG2-1:0] kk, span, j, a, b, tw;
        int unsigned       sh;
        sh   = (N_LOG2 - 1) - int'(s);
        kk   = {1'b0, kin};
        span = {{(N_LOG2-1){1'b0}}, 1'b1} << sh;
        j    = kk & (span - 1'b1);
        a    = ((kk >> sh) << (sh + 1)) | j;
        b    = a | span;                 // span bit of a is always clear
        tw   = j << s;
        return {a, b, tw[N_LOG2-2:0]};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            k         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_a_addr <= '0;
            rd_b_addr <= '0;
            tw_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        stage <= '0;
                        k     <= '0;
                        rd_en <= 1'b1;
                        {rd_a_addr, rd_b_addr, tw_addr} <= bf_addr('0, '0);
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        rd_en <= 1'b0;
                        {rd_a_addr, rd_b_addr, tw_addr} <= '0;
                    end else if (stall) begin
                        rd_en <= 1'b0;
                        {rd_a_addr, rd_b_addr, tw_addr} <= '0;
                    end else begin
                        k     <= k + 1'b1;
                        rd_en <= 1'b1;
                        {rd_a_addr, rd_b_addr, tw_addr} <= bf_addr(stage, k + 1'b1);
                    end
                end
                DRAIN: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (stage != S_LAST) begin
                        state <= RUN;
                        stage <= stage + 1'b1;
                        k     <= '0;
                        rd_en <= 1'b1;
                        {rd_a_addr, rd_b_addr, tw_addr} <= bf_addr(stage + 1'b1, '0);
                    end else begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        stage <= '0;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write path: free-running LAT-deep shift, never frozen.
    logic [LAT-1:0]    en_sr;
    logic [N_LOG2-1:0] a_sr [LAT];
    logic [N_LOG2-1:0] b_sr [LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_sr <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                a_sr[i] <= '0;
                b_sr[i] <= '0;
            end
        end else begin
            en_sr[0] <= rd_en;
            a_sr[0]  <= rd_a_addr;
            b_sr[0]  <= rd_b_addr;
            for (int unsigned i = 1; i < LAT; i++) begin
                en_sr[i] <= en_sr[i-1];
                a_sr[i]  <= a_sr[i-1];
                b_sr[i]  <= b_sr[i-1];
            end
        end
    end

    assign wr_en     = en_sr[LAT-1];
    assign wr_a_addr = a_sr[LAT-1];
    assign wr_b_addr = b_sr[LAT-1];

endmodule

// File: tb/tb_bf_addr_ctrl.sv
// tb_bf_addr_ctrl
//   Directed bench for bf_addr_ctrl with N_LOG2=4, LAT=3. Cycle c is the
//   clock period following rising edge c-1; start is sampled at edge 0.
//   Outputs are sampled on the falling edge. Define BF_ADDR_CTRL_HOLD_EN to
//   also exercise the hold input.
module tb_bf_addr_ctrl;

    localparam int N_LOG2 = 4;
    localparam int LAT    = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
`ifdef BF_ADDR_CTRL_HOLD_EN
    logic       hold = 1'b0;
`endif
    logic       busy, done, rd_en, wr_en;
    logic [3:0] stage, rd_a_addr, rd_b_addr, wr_a_addr, wr_b_addr;
    logic [2:0] tw_addr;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Hand-computed (a, b, tw) per stage, 8 butterflies each.
    int ta [32] = '{0,1,2,3,4,5,6,7,  0,1,2,3,8,9,10,11,  0,1,4,5,8,9,12,13,  0,2,4,6,8,10,12,14};
    int tb [32] = '{8,9,10,11,12,13,14,15,  4,5,6,7,12,13,14,15,  2,3,6,7,10,11,14,15,  1,3,5,7,9,11,13,15};
    int tt [32] = '{0,1,2,3,4,5,6,7,  0,2,4,6,0,2,4,6,  0,4,0,4,0,4,0,4,  0,0,0,0,0,0,0,0};

    bf_addr_ctrl #(.N_LOG2(N_LOG2), .LAT(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
`ifdef BF_ADDR_CTRL_HOLD_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (rd_b_addr),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_a_addr (wr_a_addr),
        .wr_b_addr (wr_b_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    // Table index issued in cycle c of an unstalled run, or -1 for no issue.
    function automatic int slot(input int c);
        int s, off;
        if (c < 1 || c > 44) return -1;
        s   = (c - 1) / 11;
        off = (c - 1) % 11;
        return (off < 8) ? s * 8 + off : -1;
    endfunction

    function automatic logic [31:0] all_outs();
        return {5'd0, busy, done, stage, rd_en, rd_a_addr, rd_b_addr, tw_addr,
                wr_en, wr_a_addr, wr_b_addr};
    endfunction

    task automatic check_cycle(input int c);
        int r, w;
        r = slot(c);
        w = slot(c - LAT);
        chk("rd_en", c, rd_en, r >= 0);
        if (r >= 0)
            chk("rd_addr", c, {rd_a_addr, rd_b_addr, tw_addr}, (ta[r] << 7) | (tb[r] << 3) | tt[r]);
        chk("wr_en", c, wr_en, w >= 0);
        if (w >= 0)
            chk("wr_addr", c, {wr_a_addr, wr_b_addr}, (ta[w] << 4) | tb[w]);
        chk("busy", c, busy, (c >= 1 && c <= 44));
        chk("done", c, done, c == 45);
        if (c >= 1 && c <= 44)
            chk("stage", c, stage, (c - 1) / 11);
    endtask

    // Full run; start is additionally held high in cycles lo..hi.
    task automatic run_full(input int lo, input int hi);
        int nrd, nwr;
        nrd = 0;
        nwr = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            start = (c >= lo && c <= hi);
            check_cycle(c);
            nrd += int'(rd_en);
            nwr += int'(wr_en);
        end
        start = 1'b0;
        chk("rd_count", 0, nrd, 32);
        chk("wr_count", 0, nwr, 32);
    endtask

    initial begin
        int nbusy, nrd, nwr, cdone;

        // Asynchronous reset asserted mid-clock, before any edge.
        #2 reset_n = 1'b0;
        #1 chk("reset_outs", 0, all_outs(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hold_outs", 0, all_outs(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 0, all_outs(), 0);

        // Plain run.
        run_full(-1, -1);

        // start held during busy: ignored.
        run_full(5, 20);

        // Reset in cycle 25, then restart.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("midrun_reset_outs", 25, all_outs(), 0);
        @(negedge clk);
        chk("midrun_reset_hold", 26, all_outs(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        nbusy = 0;
        nrd   = 0;
        nwr   = 0;
        cdone = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            nbusy += int'(busy);
            nrd   += int'(rd_en);
            nwr   += int'(wr_en);
            if (done) begin
                cdone = c;
                break;
            end
        end
        chk("restart_done_cycle", 0, cdone, 45);
        chk("restart_busy_cycles", 0, nbusy, 44);
        chk("restart_rd_count", 0, nrd, 32);
        chk("restart_wr_count", 0, nwr, 32);
        repeat (2) @(negedge clk);

`ifdef BF_ADDR_CTRL_HOLD_EN
        // hold seen at the edges that open cycles 14..18.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        nrd   = 0;
        cdone = -1;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            start = 1'b0;
            hold  = (c >= 13 && c <= 17);
            nrd  += int'(rd_en);
            if (done && cdone < 0) cdone = c;
            if (c >= 14 && c <= 18)
                chk("hold_rd_en", c, rd_en, 0);
            if (c == 12 || c == 13 || (c >= 19 && c <= 24)) begin
                int r;
                r = (c <= 13) ? 8 + (c - 12) : 8 + (c - 17);
                chk("hold_rd_en_on", c, rd_en, 1);
                chk("hold_rd_addr", c, {rd_a_addr, rd_b_addr, tw_addr},
                    (ta[r] << 7) | (tb[r] << 3) | tt[r]);
            end
        end
        hold = 1'b0;
        chk("hold_done_cycle", 0, cdone, 50);
        chk("hold_rd_count", 0, nrd, 32);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
